// File: rtl/tile_config_mem_clocked.sv
// tile_config_mem_clocked: clocked per-tile configuration memory.
// Frames live in flip-flops and are exported flat as ConfigBits/ConfigBits_N.
// Adds multi-hot strobe detection, a frame-load counter and a one-cycle
// frame readback port.
// Optional macro CONFIG_PARITY_EN: per-frame even parity checked on readback,
// with a force_parity_flip input to corrupt the stored parity deliberately.
module tile_config_mem_clocked #(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NoConfigBits    = 640,
    parameter int CntWidth        = 8,
    localparam int RbW  = ($clog2(MaxFramesPerCol) > 0) ? $clog2(MaxFramesPerCol) : 1,
    localparam int CbW  = (NoConfigBits > 0) ? NoConfigBits : 1
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic [FrameBitsPerRow-1:0] FrameData,
    input  logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic [CbW-1:0]             ConfigBits,
    output logic [CbW-1:0]             ConfigBits_N,
    input  logic                       rb_req,
    input  logic [RbW-1:0]             rb_frame,
    output logic                       rb_valid,
    output logic [FrameBitsPerRow-1:0] rb_data,
    output logic                       rb_oob,
    output logic                       strobe_err,
    output logic [CntWidth-1:0]        frames_loaded
`ifdef CONFIG_PARITY_EN
    ,
    input  logic                       force_parity_flip,
    output logic                       rb_parity_err
`endif
);

    localparam int TotalBits = MaxFramesPerCol * FrameBitsPerRow;

    // All frames packed back to back: frame i occupies bits [i*FB +: FB],
    // which is exactly the ConfigBits ordering.
    logic [TotalBits-1:0]       mem;
    logic [MaxFramesPerCol-1:0] strobe_p1;
    logic                       strobe_onehot;
    logic                       strobe_multi;
    logic                       strobe_rise;
    logic [FrameBitsPerRow-1:0] rd_frame;
    logic                       rd_hit;

    function automatic logic is_onehot(input logic [MaxFramesPerCol-1:0] s);
        return (s != '0) && ((s & (s - 1'b1)) == '0);
    endfunction

    function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] c);
        return (c == {CntWidth{1'b1}}) ? c : c + 1'b1;
    endfunction

    // Strobe classification; a multi-hot strobe is an error and writes nothing.
    always_comb begin
        strobe_onehot = is_onehot(FrameStrobe);
        strobe_multi  = (FrameStrobe != '0) && !strobe_onehot;
        strobe_rise   = strobe_onehot && ((FrameStrobe & ~strobe_p1) != '0);
    end

    // Frame storage: a one-hot strobe overwrites the selected frame every cycle it is held.
    always_ff @(posedge CLK) begin
        if (reset) begin
            mem <= '0;
        end else if (strobe_onehot) begin
            for (int i = 0; i < MaxFramesPerCol; i++) begin
                if (FrameStrobe[i]) begin
                    mem[i*FrameBitsPerRow +: FrameBitsPerRow] <= FrameData;
                end
            end
        end
    end

    // Strobe history, sticky error flag and saturating load counter.
    always_ff @(posedge CLK) begin
        if (reset) begin
            strobe_p1     <= '0;
            strobe_err    <= 1'b0;
            frames_loaded <= '0;
        end else begin
            strobe_p1 <= FrameStrobe;
            if (strobe_multi) begin
                strobe_err <= 1'b1;
            end
            if (strobe_rise) begin
                frames_loaded <= sat_inc(frames_loaded);
            end
        end
    end

    // Readback mux; an index with no matching frame leaves rd_hit low and data zero.
    always_comb begin
        rd_frame = '0;
        rd_hit   = 1'b0;
        for (int i = 0; i < MaxFramesPerCol; i++) begin
            if (rb_frame == RbW'(i)) begin
                rd_frame = mem[i*FrameBitsPerRow +: FrameBitsPerRow];
                rd_hit   = 1'b1;
            end
        end
    end

    // Readback register: samples pre-write contents; data holds between requests.
    always_ff @(posedge CLK) begin
        if (reset) begin
            rb_valid <= 1'b0;
            rb_data  <= '0;
            rb_oob   <= 1'b0;
        end else begin
            rb_valid <= rb_req;
            rb_oob   <= rb_req && !rd_hit;
            if (rb_req) begin
                rb_data <= rd_frame;
            end
        end
    end

`ifdef CONFIG_PARITY_EN
    logic [MaxFramesPerCol-1:0] par_mem;
    logic                       rd_par;

    // Stored parity for the frame being read back.
    always_comb begin
        rd_par = 1'b0;
        for (int i = 0; i < MaxFramesPerCol; i++) begin
            if (rb_frame == RbW'(i)) begin
                rd_par = par_mem[i];
            end
        end
    end

    // Parity storage written alongside the frame, optionally inverted.
    always_ff @(posedge CLK) begin
        if (reset) begin
            par_mem <= '0;
        end else if (strobe_onehot) begin
            for (int i = 0; i < MaxFramesPerCol; i++) begin
                if (FrameStrobe[i]) begin
                    par_mem[i] <= (^FrameData) ^ force_parity_flip;
                end
            end
        end
    end

    // Parity check result aligned with rb_valid.
    always_ff @(posedge CLK) begin
        if (reset) begin
            rb_parity_err <= 1'b0;
        end else begin
            rb_parity_err <= rb_req && rd_hit && ((^rd_frame) != rd_par);
        end
    end
`endif

    // Config export straight from the frame registers.
    generate
        if (NoConfigBits > 0) begin : g_cfg
            assign ConfigBits   = mem[CbW-1:0];
            assign ConfigBits_N = ~mem[CbW-1:0];
        end else begin : g_nocfg
            // Zero-width export: single unused bit tied off.
            assign ConfigBits   = '0;
            assign ConfigBits_N = '0;
        end
    endgenerate

endmodule

// File: tb/tb_tile_config_mem_clocked.sv
// Testbench for tile_config_mem_clocked: directed stimulus, readback responses
// checked by a scoreboard monitor, static state checked inline.
module tb_tile_config_mem_clocked;

    logic         CLK = 1'b0;
    logic         reset;
    logic [31:0]  FrameData;
    logic [19:0]  FrameStrobe;
    logic [639:0] ConfigBits;
    logic [639:0] ConfigBits_N;
    logic         rb_req;
    logic [4:0]   rb_frame;
    logic         rb_valid;
    logic [31:0]  rb_data;
    logic         rb_oob;
    logic         strobe_err;
    logic [7:0]   frames_loaded;
    logic         force_parity_flip;
    logic         rb_parity_err;

    typedef struct {
        logic [31:0] data;
        logic        oob;
        logic        perr;
    } rb_exp_t;

    rb_exp_t exp_q[$];
    int checks   = 0;
    int failures = 0;

    tile_config_mem_clocked dut (
        .CLK           (CLK),
        .reset         (reset),
        .FrameData     (FrameData),
        .FrameStrobe   (FrameStrobe),
        .ConfigBits    (ConfigBits),
        .ConfigBits_N  (ConfigBits_N),
        .rb_req        (rb_req),
        .rb_frame      (rb_frame),
        .rb_valid      (rb_valid),
        .rb_data       (rb_data),
        .rb_oob        (rb_oob),
        .strobe_err    (strobe_err),
        .frames_loaded (frames_loaded)
`ifdef CONFIG_PARITY_EN
        ,
        .force_parity_flip (force_parity_flip),
        .rb_parity_err     (rb_parity_err)
`endif
    );

`ifndef CONFIG_PARITY_EN
    assign rb_parity_err = 1'b0;
`endif

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [639:0] act, input logic [639:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_rb(input logic [31:0] d, input logic oob, input logic perr);
        rb_exp_t e;
        e.data = d;
        e.oob  = oob;
        e.perr = perr;
        exp_q.push_back(e);
    endtask

    function automatic logic [31:0] frame_of(input int k);
        return ConfigBits[k*32 +: 32];
    endfunction

    // Monitor: every valid readback cycle pops one expected response.
    always @(negedge CLK) begin
        if (rb_valid === 1'b1) begin
            rb_exp_t e;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rb_unexpected actual=valid required=no response");
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (rb_data !== e.data || rb_oob !== e.oob || rb_parity_err !== e.perr) begin
                    failures++;
                    $display("FAIL rb_resp actual=data %0h oob %0b perr %0b required=data %0h oob %0b perr %0b",
                             rb_data, rb_oob, rb_parity_err, e.data, e.oob, e.perr);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; FrameData = '0; FrameStrobe = '0;
        rb_req = 1'b0; rb_frame = '0; force_parity_flip = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();

        // Reset state
        check("rst_cfg",    ConfigBits, '0);
        check("rst_cfg_n",  ConfigBits_N, {640{1'b1}});
        check("rst_loaded", {632'd0, frames_loaded}, 640'd0);
        check("rst_err",    {639'd0, strobe_err}, 640'd0);
        check("rst_valid",  {639'd0, rb_valid}, 640'd0);

        // First and last frame
        FrameStrobe = 20'h00001; FrameData = 32'hDEADBEEF; tick();
        FrameStrobe = 20'h80000; FrameData = 32'h12345678; tick();
        FrameStrobe = '0; tick();
        check("frame0",   {608'd0, ConfigBits[31:0]}, {608'd0, 32'hDEADBEEF});
        check("frame19",  {608'd0, ConfigBits[639:608]}, {608'd0, 32'h12345678});
        check("cfg_n_f0", {608'd0, ConfigBits_N[31:0]}, {608'd0, 32'h21524110});
        check("loaded2",  {632'd0, frames_loaded}, 640'd2);

        // Held strobe: last value wins, counted once
        for (int i = 1; i <= 4; i++) begin
            FrameStrobe = 20'h00008; FrameData = i; tick();
        end
        FrameStrobe = '0; tick();
        check("frame3_held", {608'd0, frame_of(3)}, {608'd0, 32'd4});
        check("loaded3",     {632'd0, frames_loaded}, 640'd3);

        // Multi-hot strobe
        FrameStrobe = 20'h00006; FrameData = 32'hFFFFFFFF; tick();
        FrameStrobe = '0;
        check("mh_frame1", {608'd0, frame_of(1)}, 640'd0);
        check("mh_frame2", {608'd0, frame_of(2)}, 640'd0);
        check("mh_err",    {639'd0, strobe_err}, 640'd1);
        check("mh_loaded", {632'd0, frames_loaded}, 640'd3);
        repeat (10) tick();
        check("mh_err_sticky", {639'd0, strobe_err}, 640'd1);
        reset = 1'b1; tick();
        reset = 1'b0; tick();
        check("mh_err_clr",  {639'd0, strobe_err}, 640'd0);
        check("rst2_cfg",    ConfigBits, '0);
        check("rst2_loaded", {632'd0, frames_loaded}, 640'd0);

        // Readback: same-cycle write returns old data, back-to-back, out of range
        FrameStrobe = 20'h00020; FrameData = 32'hA5A5A5A5; tick();
        FrameData = 32'h0F0F0F0F; rb_req = 1'b1; rb_frame = 5'd5;
        push_rb(32'hA5A5A5A5, 1'b0, 1'b0); tick();
        FrameStrobe = '0; rb_frame = 5'd5;
        push_rb(32'h0F0F0F0F, 1'b0, 1'b0); tick();
        rb_frame = 5'd25;
        push_rb(32'h0, 1'b1, 1'b0); tick();
        rb_frame = 5'd4;
        push_rb(32'h0, 1'b0, 1'b0); tick();
        rb_req = 1'b0; tick();
        check("idle_valid", {639'd0, rb_valid}, 640'd0);
        check("idle_oob",   {639'd0, rb_oob}, 640'd0);
        check("loaded_f5",  {632'd0, frames_loaded}, 640'd1);

        // Counter saturation
        for (int i = 0; i < 260; i++) begin
            FrameStrobe = 20'h00001; FrameData = i; tick();
            FrameStrobe = '0; tick();
        end
        check("loaded_sat", {632'd0, frames_loaded}, 640'd255);
        check("frame0_last", {608'd0, frame_of(0)}, {608'd0, 32'd259});

`ifdef CONFIG_PARITY_EN
        // Forced parity corruption, then a clean write
        force_parity_flip = 1'b1; FrameStrobe = 20'h00001; FrameData = 32'h1; tick();
        force_parity_flip = 1'b0; FrameStrobe = '0;
        rb_req = 1'b1; rb_frame = 5'd0; push_rb(32'h1, 1'b0, 1'b1); tick();
        rb_req = 1'b0; FrameStrobe = 20'h00001; FrameData = 32'h3; tick();
        FrameStrobe = '0;
        rb_req = 1'b1; rb_frame = 5'd0; push_rb(32'h3, 1'b0, 1'b0); tick();
        rb_req = 1'b0; tick();
`endif

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL rb_drain actual=%0d pending required=0 pending", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tile_config_mem_clocked.md
Name: tile_config_mem_clocked

Overview:
- Clocked successor to the per-tile frame-latch configuration memory.
- Stores MaxFramesPerCol frames of FrameBitsPerRow bits in flip-flops.
- Drives the flattened ConfigBits and ConfigBits_N vectors to the tile switch matrix and BELs.
- Adds synchronous reset, strobe-error detection, a frame-load counter and a one-cycle frame readback port for configuration verification.

Parameters:
- MaxFramesPerCol, 20, number of frames, equal to the strobe width.
- FrameBitsPerRow, 32, bits per frame, equal to the data width.
- NoConfigBits, 640, number of config bits exported; legal range 0 to MaxFramesPerCol*FrameBitsPerRow.
- CntWidth, 8, width of the frame-load counter.

Ports:
- CLK  input  1  configuration clock.
- reset  input  1  synchronous, active-high reset.
- FrameData  input  FrameBitsPerRow  frame payload.
- FrameStrobe  input  MaxFramesPerCol  one-hot frame write select.
- ConfigBits  output  NoConfigBits  configuration bits.
- ConfigBits_N  output  NoConfigBits  bitwise complement of ConfigBits.
- rb_req  input  1  readback request, one cycle per request.
- rb_frame  input  clog2(MaxFramesPerCol)  frame index to read back.
- rb_valid  output  1  readback data valid.
- rb_data  output  FrameBitsPerRow  frame contents returned by readback.
- rb_oob  output  1  requested index was out of range.
- strobe_err  output  1  sticky flag: a multi-hot strobe was seen.
- frames_loaded  output  CntWidth  saturating count of frame-load events.

Behaviour:
- Reset:
  - All frame registers clear to 0, so ConfigBits=0 and ConfigBits_N=all ones.
  - rb_valid, rb_data, rb_oob, strobe_err, frames_loaded and the previous-strobe register clear to 0.
  - Reset has priority over every other event in the same cycle, including a write, a readback request and a counter increment.
- Write:
  - When FrameStrobe is exactly one-hot with bit i set, frame[i] <= FrameData at the rising edge.
  - A strobe held high for N cycles writes on every one of those cycles; the last value wins.
- Strobe errors:
  - A multi-hot FrameStrobe writes nothing and sets strobe_err.
  - strobe_err stays set until reset.
  - FrameStrobe=0 is idle.
- Load counter:
  - frames_loaded increments by 1 on each one-hot strobe whose bit was 0 in the previous cycle (rising-edge detect on a registered copy of FrameStrobe).
  - The counter saturates at 2^CntWidth-1.
- Config mapping:
  - ConfigBits[k] = frame[k / FrameBitsPerRow][k % FrameBitsPerRow] for k < NoConfigBits.
  - Frame bits beyond NoConfigBits are still stored and can be read back.
  - ConfigBits and ConfigBits_N come directly from registers, with no combinational path from the inputs.
- Readback:
  - rb_req at cycle t gives rb_valid=1 at t+1, with rb_data = frame[rb_frame] as it was before the cycle-t write.
  - A same-cycle write to the same frame therefore returns the old data.
  - rb_req may be asserted back-to-back; each request produces its own valid at t+1.
  - rb_valid is 0 in any cycle not preceded by rb_req.
  - rb_data holds its last value while rb_valid=0.
- Out-of-range readback: rb_frame >= MaxFramesPerCol returns rb_data=0 and rb_oob=1, both for that one valid cycle only.
- NoConfigBits=0: ConfigBits and ConfigBits_N are not driven (zero width). Storage, readback and the counter still operate.

Optional Feature:
- Macro name: CONFIG_PARITY_EN.
- When defined:
  - Each frame stores an extra even-parity bit computed from FrameData at write time.
  - On readback, parity is recomputed; if it mismatches, output rb_parity_err=1 in the rb_valid cycle.
  - A force_parity_flip input (1 bit) inverts the stored parity on the next write, for verification.
  - Reset clears all parity bits to 0, which is consistent with all-zero frames.
- When not defined: no parity storage and no rb_parity_err or force_parity_flip ports; all other behaviour is identical.

Test Plan:
- Reset then idle -> ConfigBits=0, ConfigBits_N=all ones, frames_loaded=0, strobe_err=0, rb_valid=0.
- FrameStrobe=0x00001 with FrameData=0xDEADBEEF, then strobe=0x80000 with FrameData=0x12345678 -> ConfigBits[31:0]=0xDEADBEEF, ConfigBits[639:608]=0x12345678, frames_loaded=2.
- Hold strobe bit 3 for 4 cycles with data 1,2,3,4 -> frame 3 = 4, frames_loaded increments only once.
- FrameStrobe=0x00006 with data 0xFFFFFFFF -> frames 1 and 2 unchanged, strobe_err=1 and still 1 after 10 idle cycles, cleared by reset.
- Write frame 5 = 0xA5A5A5A5, then in one cycle assert rb_req for frame 5 and write frame 5 = 0x0F0F0F0F -> next cycle rb_valid=1 with rb_data=0xA5A5A5A5; a following request returns 0x0F0F0F0F. rb_frame=25 -> rb_data=0, rb_oob=1.
- With CONFIG_PARITY_EN defined: write frame 0 with force_parity_flip=1, then read back -> rb_parity_err=1. A normal write then readback -> rb_parity_err=0.
